conv_encoder_framer: RTL and testbench

// - Upstream stage of the vitebri decoder: K=3, rate-1/2 convolutional encoder with framing.
// - Accepts one FRAME_BITS-bit data word per frame and shifts it out MSB-first as 2-bit code symbols.
// - Appends K-1 zero tail bits so the trellis terminates in state 0.
// - Output stream (FRAME_BITS+K-1 = 64 symbols) drives the decoder data_in/valid_input directly.

---
 rtl/viterbi_pkg.sv | 19 +
 rtl/conv_encoder_framer_if.sv | 30 +++
 rtl/conv_enc_core.sv | 44 ++++
 rtl/conv_encoder_framer.sv | 120 ++++++++++++
 tb/tb_conv_encoder_framer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared parameters for the convolutional encoder framer and the decoder.
// Holds the frame geometry, the code generators and the framer FSM state
// encoding, so encoder and decoder always agree on the trellis.
package viterbi_pkg;

    localparam int FRAME_BITS = 62;                       // payload bits per frame
    localparam int K          = 3;                        // constraint length
    localparam logic [K-1:0] G0 = 3'b111;                 // sym_out[1]; MSB taps current bit
    localparam logic [K-1:0] G1 = 3'b101;                 // sym_out[0]; MSB taps current bit
    localparam int N_SYMS     = FRAME_BITS + K - 1;       // symbols per frame incl. tail
    localparam int CNT_W      = $clog2(FRAME_BITS + K);   // symbol counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/conv_encoder_framer_if.sv
// Handshake bundle of the convolutional encoder framer.
//   in_valid/in_ready/data_in   : frame input handshake
//   sym_out/sym_valid/sym_ready : code symbol output handshake
//   sym_last                    : marks the final tail symbol
//   busy                        : framer is not idle
// modport master : the framer itself (drives ready/symbols)
// modport slave  : the environment (drives frames and sym_ready)
interface conv_encoder_framer_if;
    import viterbi_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [FRAME_BITS-1:0] data_in;
    logic [1:0]            sym_out;
    logic                  sym_valid;
    logic                  sym_ready;
    logic                  sym_last;
    logic                  busy;

    modport master (
        input  in_valid, data_in, sym_ready,
        output in_ready, sym_out, sym_valid, sym_last, busy
    );

    modport slave (
        output in_valid, data_in, sym_ready,
        input  in_ready, sym_out, sym_valid, sym_last, busy
    );

endinterface

// File: rtl/conv_enc_core.sv
// K=3 rate-1/2 convolutional encoder core.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   en         : advance the encoder register with bit_in
//   clr        : clear the encoder register (wins over en)
//   bit_in     : current input bit b
//   sym        : {G0 parity, G1 parity} of {b, s}, combinational
module conv_enc_core
    import viterbi_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic       bit_in,
    output logic [1:0] sym
);

    // s_q[K-2] holds the newest past bit, s_q[0] the oldest.
    logic [K-2:0] s_q;
    logic [K-2:0] s_d;
    logic [K-1:0] v;

    assign v   = {bit_in, s_q};
    assign sym = {^(v & G0), ^(v & G1)};

    always_comb begin
        s_d = s_q;
        if (clr) begin
            s_d = '0;
        end else if (en) begin
            s_d = {bit_in, s_q[K-2:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/conv_encoder_framer.sv
// Convolutional encoder framer: accepts one FRAME_BITS-bit word per frame and
// emits FRAME_BITS+K-1 registered 2-bit code symbols, MSB first, followed by
// K-1 zero tail bits so the decoder trellis ends in state 0.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   bus        : conv_encoder_framer_if.master (frame in, symbols out, busy)
module conv_encoder_framer
    import viterbi_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    conv_encoder_framer_if.master bus
);

    fsm_state_t            state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            sym_out_q, sym_out_d;
    logic                  sym_valid_q, sym_valid_d;
    logic                  sym_last_q, sym_last_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;

    logic                  load;      // produce the next symbol into the output register
    logic                  enc_clr;
    logic [1:0]            enc_sym;

    // The shift register fills with zeros, so once the payload is exhausted
    // its MSB supplies the tail bits without any extra muxing.
    conv_enc_core u_core (
        .clk    (clk),
        .reset  (reset),
        .en     (load),
        .clr    (enc_clr),
        .bit_in (shift_q[FRAME_BITS-1]),
        .sym    (enc_sym)
    );

    // cnt_q is the index of the symbol currently held in the output register.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        sym_out_d   = sym_out_q;
        sym_valid_d = sym_valid_q;
        sym_last_d  = sym_last_q;
        load        = 1'b0;
        enc_clr     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    shift_d = bus.data_in;
                    cnt_d   = '0;
                    enc_clr = 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_DATA, ST_TAIL: begin
                if (!sym_valid_q) begin
                    // First cycle after accept: fill the empty output register.
                    load = 1'b1;
                end else if (bus.sym_ready) begin
                    if (cnt_q == CNT_W'(N_SYMS - 1)) begin
                        state_d     = ST_IDLE;
                        sym_valid_d = 1'b0;
                        sym_last_d  = 1'b0;
                        sym_out_d   = 2'b00;
                    end else begin
                        load  = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                            state_d = ST_TAIL;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            sym_out_d   = enc_sym;
            sym_valid_d = 1'b1;
            sym_last_d  = (cnt_d == CNT_W'(N_SYMS - 1));
            shift_d     = {shift_q[FRAME_BITS-2:0], 1'b0};
        end

        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            sym_out_q   <= 2'b00;
            sym_valid_q <= 1'b0;
            sym_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
            sym_last_q  <= sym_last_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.sym_out   = sym_out_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.sym_last  = sym_last_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Self-checking bench for conv_encoder_framer. A frame-level model turns each
// accepted word into its 64 expected symbols (generator taps as bit delays),
// and a negedge monitor checks every output on every cycle against it.
module tb_conv_encoder_framer;
    import viterbi_pkg::*;

    logic clk;
    logic reset;
    conv_encoder_framer_if bus ();

    conv_encoder_framer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // model state
    logic [1:0] exp_q[$];
    bit         prime = 0;      // cycle right after accept: output register still empty
    bit         mon_en = 0;
    bit         m_idle, m_valid;
    int         hs_count = 0;
    logic [1:0] dut_syms [N_SYMS];
    logic       dut_last [N_SYMS];
    int         hs_cycle [N_SYMS];

    logic [1:0] prefix_exp [8] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 2'b00};
    logic [1:0] tail_exp   [3] = '{2'b10, 2'b11, 2'b00};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Input bit i of the frame: payload MSB first, zero outside the payload.
    function automatic logic bit_at(input logic [FRAME_BITS-1:0] d, input int i);
        if (i < 0 || i >= FRAME_BITS) return 1'b0;
        return d[FRAME_BITS-1-i];
    endfunction

    // G0=111 -> b(i)^b(i-1)^b(i-2); G1=101 -> b(i)^b(i-2).
    function automatic logic [1:0] model_sym(input logic [FRAME_BITS-1:0] d, input int i);
        logic b0, b1, b2;
        b0 = bit_at(d, i);
        b1 = bit_at(d, i - 1);
        b2 = bit_at(d, i - 2);
        return {b0 ^ b1 ^ b2, b0 ^ b2};
    endfunction

    function automatic logic [FRAME_BITS-1:0] rand62();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[FRAME_BITS-1:0];
    endfunction

    // Per-cycle compare against the model, then apply the edge that follows.
    always @(negedge clk) begin
        if (mon_en) begin
            m_idle  = (exp_q.size() == 0);
            m_valid = !m_idle && !prime;
            check("in_ready", bus.in_ready, m_idle);
            check("busy", bus.busy, !m_idle);
            check("sym_valid", bus.sym_valid, m_valid);
            if (m_valid) begin
                check("sym_out", bus.sym_out, exp_q[0]);
                check("sym_last", bus.sym_last, exp_q.size() == 1);
            end else begin
                check("sym_last_idle", bus.sym_last, 1'b0);
            end
            if (!reset) begin
                exp_q.delete();
                prime = 0;
            end else begin
                if (m_valid && bus.sym_ready) begin
                    if (hs_count < N_SYMS) begin
                        dut_syms[hs_count] = bus.sym_out;
                        dut_last[hs_count] = bus.sym_last;
                        hs_cycle[hs_count] = cyc;
                    end
                    hs_count++;
                    void'(exp_q.pop_front());
                end
                prime = 0;
                if (bus.in_valid && m_idle) begin
                    for (int i = 0; i < N_SYMS; i++) exp_q.push_back(model_sym(bus.data_in, i));
                    prime = 1;
                    hs_count = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one frame and drive sym_ready until all symbols are taken.
    // bp_at/bp_len: stall window; rst_at: abort with reset; rnd: random ready/in_valid.
    task automatic send_frame(input logic [FRAME_BITS-1:0] d, input int bp_at, input int bp_len,
                              input int rst_at, input bit rnd);
        int  guard;
        int  bp_left;
        bit  bp_done;
        bit  aborted;
        bus.data_in   = d;
        bus.in_valid  = 1'b1;
        bus.sym_ready = 1'b1;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) check("accept_timeout", 1'b0, 1'b1);
        tick();
        bus.in_valid = rnd;
        bus.data_in  = rand62();
        bp_left = 0;
        bp_done = 0;
        aborted = 0;
        guard   = 0;
        while (hs_count < N_SYMS && guard < 2000) begin
            if (rst_at >= 0 && hs_count == rst_at) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
                aborted = 1;
                break;
            end
            if (!bp_done && hs_count == bp_at) begin
                bp_left = bp_len;
                bp_done = 1;
            end
            if (bp_left > 0) begin
                bus.sym_ready = 1'b0;
                bp_left--;
            end else if (rnd) begin
                bus.sym_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.sym_ready = 1'b1;
            end
            if (rnd) begin
                bus.in_valid = (hs_count < N_SYMS - 1);
                bus.data_in  = rand62();
            end
            tick();
            guard++;
        end
        bus.in_valid  = 1'b0;
        bus.sym_ready = 1'b1;
        if (aborted) begin
            @(negedge clk);
            check("midreset_valid", bus.sym_valid, 1'b0);
            tick();
        end else begin
            check("frame_timeout", guard < 2000, 1'b1);
            check("in_ready_after_last", bus.in_ready, 1'b1);
            check("hs_total", hs_count, N_SYMS);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    logic [FRAME_BITS-1:0] d;

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.data_in   = rand62();
        bus.sym_ready = 1'b1;

        // Reset held with in_valid high: nothing accepted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_sym_valid", bus.sym_valid, 1'b0);
            check("rst_sym_last", bus.sym_last, 1'b0);
            check("rst_busy", bus.busy, 1'b0);
            check("rst_in_ready", bus.in_ready, 1'b1);
        end
        @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        mon_en       = 1;
        @(negedge clk);
        check("post_rst_busy", bus.busy, 1'b0);
        tick();

        // Prefix and tail pinned by hand-computed symbols.
        d = rand62();
        d[FRAME_BITS-1 -: 8] = 8'b10011101;
        d[2:0] = 3'b010;
        for (int i = 0; i < 8; i++) check("model_prefix", model_sym(d, i), prefix_exp[i]);
        for (int i = 0; i < 3; i++) check("model_tail", model_sym(d, 61 + i), tail_exp[i]);
        send_frame(d, -1, 0, -1, 0);
        for (int i = 0; i < 8; i++) check("dut_prefix", dut_syms[i], prefix_exp[i]);
        for (int i = 0; i < 3; i++) check("dut_tail", dut_syms[61 + i], tail_exp[i]);
        check("last_on_63", dut_last[63], 1'b1);
        check("last_not_62", dut_last[62], 1'b0);
        check("consecutive", hs_cycle[63] - hs_cycle[0], 63);
        $display("frame prefix/tail: %0d symbols", hs_count);

        // Backpressure for 5 cycles at symbol 10.
        send_frame(rand62(), 10, 5, -1, 0);
        check("bp_gap", hs_cycle[10] - hs_cycle[9], 6);
        $display("frame backpressure: %0d symbols", hs_count);

        // Reset mid-frame, then an all-zero frame.
        send_frame(rand62(), -1, 0, 30, 0);
        $display("frame aborted at symbol 30");
        send_frame('0, -1, 0, -1, 0);
        for (int i = 0; i < N_SYMS; i++) check("zero_frame", dut_syms[i], 2'b00);
        $display("frame zero: %0d symbols", hs_count);

        // Random frames with random backpressure and stray in_valid.
        for (int f = 0; f < 20; f++) begin
            d = rand62();
            send_frame(d, -1, 0, -1, 1);
            $display("frame random %0d data=%h: %0d symbols", f, d, hs_count);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
